acc_reg_bank: RTL and testbench

Banked, parametrised successor to the single-bank accumulator register file. It holds NB banks of 2**D registers, W bits each, with a dedicated accumulator per bank, two read ports and optional write-to-read bypass. A background sequencer clears or copies a whole bank one register per cycle, which supports interrupt context switching. It sits in the processor datapath between decode/ALU and writeback.

---
 rtl/acc_reg_pkg.sv | 7 +
 rtl/reg_bank_array.sv | 36 +++
 rtl/acc_reg_bank.sv | 91 +++++++++
 tb/tb_acc_reg_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/acc_reg_pkg.sv
// acc_reg_pkg: shared sequencer state encoding and default sizing for the banked accumulator register file
package acc_reg_pkg;
   typedef enum logic [1:0] {IDLE, CLEAR, COPY} state_t;
   localparam int W_DEF  = 8;
   localparam int D_DEF  = 4;
   localparam int NB_DEF = 2;
endpackage

// File: rtl/reg_bank_array.sv
// reg_bank_array: NB x 2**D register storage with two read ports, accumulator read, sweep read and one write port
module reg_bank_array
   import acc_reg_pkg::*;
#(
   parameter int W   = W_DEF,
   parameter int D   = D_DEF,
   parameter int NB  = NB_DEF,
   parameter int BW  = (NB > 1) ? $clog2(NB) : 1,
   parameter int ACC = 2**D - 1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          we,
   input  logic [BW-1:0] wbank,
   input  logic [D-1:0]  waddr,
   input  logic [W-1:0]  wdata,
   input  logic [BW-1:0] rbank,
   input  logic [D-1:0]  raddr_a,
   input  logic [D-1:0]  raddr_b,
   input  logic [BW-1:0] sbank,
   input  logic [D-1:0]  saddr,
   output logic [W-1:0]  rdata_a,
   output logic [W-1:0]  rdata_b,
   output logic [W-1:0]  rdata_acc,
   output logic [W-1:0]  sdata
);
   localparam logic [D-1:0] ACC_A = D'(ACC);
   logic [W-1:0] mem [NB*(2**D)];
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) for (int i = 0; i < NB*(2**D); i++) mem[i] <= '0;
      else if (we) mem[{wbank, waddr}] <= wdata;
   assign rdata_a   = mem[{rbank, raddr_a}];
   assign rdata_b   = mem[{rbank, raddr_b}];
   assign rdata_acc = mem[{rbank, ACC_A}];
   assign sdata     = mem[{sbank, saddr}];
endmodule

// File: rtl/acc_reg_bank.sv
// acc_reg_bank: banked accumulator register file with write bypass and a background clear/copy sequencer
module acc_reg_bank
   import acc_reg_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int D      = D_DEF,
   parameter int NB     = NB_DEF,
   parameter int BW     = (NB > 1) ? $clog2(NB) : 1,
   parameter int ACC    = 2**D - 1,
   parameter int BYPASS = 1
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          reg_write_en,
   input  logic          acc_write_en,
   input  logic [D-1:0]  waddr,
   input  logic [W-1:0]  data_in,
   input  logic [D-1:0]  raddr_a,
   input  logic [D-1:0]  raddr_b,
   output logic [W-1:0]  data_out_a,
   output logic [W-1:0]  data_out_b,
   output logic [W-1:0]  data_out_acc,
   input  logic          bank_load,
   input  logic [BW-1:0] bank_sel,
   input  logic          clr_req,
   input  logic          copy_req,
   input  logic [BW-1:0] copy_dst,
   output logic          busy,
   output logic          done
);
   localparam logic [D-1:0] ACC_A = D'(ACC);
   state_t        state;
   logic [D-1:0]  idx, wr_addr, arr_waddr;
   logic [BW-1:0] bank, src, dst, arr_wbank;
   logic          idle, wr_en, arr_we;
   logic [W-1:0]  arr_wdata, rd_a, rd_b, rd_acc, sw_data;

   assign idle      = state == IDLE;
   assign wr_en     = idle && (acc_write_en || reg_write_en);
   assign wr_addr   = acc_write_en ? ACC_A : waddr;
   assign arr_we    = wr_en || !idle;
   assign arr_wbank = (state == COPY) ? dst : bank;
   assign arr_waddr = idle ? wr_addr : idx;
   assign arr_wdata = idle ? data_in : (state == COPY) ? sw_data : '0;

   // Forwarding only ever covers port writes; sweep data is visible once committed
   assign data_out_a   = (BYPASS != 0 && wr_en && raddr_a == wr_addr) ? data_in : rd_a;
   assign data_out_b   = (BYPASS != 0 && wr_en && raddr_b == wr_addr) ? data_in : rd_b;
   assign data_out_acc = (BYPASS != 0 && wr_en && wr_addr == ACC_A) ? data_in : rd_acc;

   reg_bank_array #(.W(W), .D(D), .NB(NB), .BW(BW), .ACC(ACC)) u_array (
      .CLK(CLK), .RST_N(RST_N),
      .we(arr_we), .wbank(arr_wbank), .waddr(arr_waddr), .wdata(arr_wdata),
      .rbank(bank), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .sbank(src), .saddr(idx),
      .rdata_a(rd_a), .rdata_b(rd_b), .rdata_acc(rd_acc), .sdata(sw_data)
   );

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state <= IDLE;
         idx   <= '0;
         bank  <= '0;
         src   <= '0;
         dst   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (idle) begin
            if (clr_req) begin
               state <= CLEAR;
               idx   <= '0;
               busy  <= 1'b1;
            end else if (copy_req) begin
               state <= COPY;
               idx   <= '0;
               src   <= bank;
               dst   <= copy_dst;
               busy  <= 1'b1;
            end else if (bank_load) bank <= bank_sel;
         end else begin
            idx <= idx + 1'b1;
            if (idx == '1) begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_acc_reg_bank.sv
// tb_acc_reg_bank: directed stimulus with a queued scoreboard checked by an independent negedge monitor
module tb_acc_reg_bank;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic reg_write_en = 0, acc_write_en = 0, bank_load = 0, clr_req = 0, copy_req = 0;
  logic [3:0] waddr = 0, raddr_a = 0, raddr_b = 0;
  logic [7:0] data_in = 0;
  logic [0:0] bank_sel = 0, copy_dst = 0;
  logic [7:0] data_out_a, data_out_b, data_out_acc;
  logic busy, done;
  acc_reg_bank dut (
    .CLK(CLK), .RST_N(RST_N),
    .reg_write_en(reg_write_en), .acc_write_en(acc_write_en),
    .waddr(waddr), .data_in(data_in),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .data_out_a(data_out_a), .data_out_b(data_out_b), .data_out_acc(data_out_acc),
    .bank_load(bank_load), .bank_sel(bank_sel),
    .clr_req(clr_req), .copy_req(copy_req), .copy_dst(copy_dst),
    .busy(busy), .done(done)
  );
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] exp;
  } chk_t;
  chk_t q[$];
  int total = 0, bad = 0, done_cnt = 0;
  always @(negedge CLK) begin
    chk_t c;
    logic [7:0] act;
    string nm;
    if (done) done_cnt++;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.kind)
        3'd0: begin act = data_out_a; nm = "data_out_a"; end
        3'd1: begin act = data_out_b; nm = "data_out_b"; end
        3'd2: begin act = data_out_acc; nm = "data_out_acc"; end
        3'd3: begin act = {7'd0, busy}; nm = "busy"; end
        3'd4: begin act = {7'd0, done}; nm = "done"; end
        default: begin act = done_cnt[7:0]; nm = "done_count"; end
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, c.exp);
      end
    end
  end
  task automatic chk(input logic [2:0] k, input logic [7:0] e);
    q.push_back({k, e});
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle_inputs();
    reg_write_en = 0; acc_write_en = 0; bank_load = 0; clr_req = 0; copy_req = 0;
  endtask
  task automatic sel_bank(input logic [0:0] b);
    bank_load = 1; bank_sel = b;
    step();
    bank_load = 0;
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    reg_write_en = 1; waddr = a; data_in = d;
    step();
    reg_write_en = 0;
  endtask
  task automatic expect_zero_bank();
    for (int i = 0; i < 16; i++) begin
      raddr_a = 4'(i); raddr_b = 4'(15 - i);
      chk(0, 8'h00); chk(1, 8'h00);
      step();
    end
  endtask
  task automatic sweep_wait(input bit poke);
    for (int k = 0; k < 16; k++) begin
      chk(3, 8'h01); chk(4, 8'h00);
      if (poke && k == 5) begin
        reg_write_en = 1; waddr = 4'd4; data_in = 8'hFF; raddr_a = 4'd4;
        chk(0, 8'h04);
      end
      step();
      reg_write_en = 0;
    end
    chk(3, 8'h00); chk(4, 8'h01);
    step();
    chk(4, 8'h00);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    step(); step();
    chk(0, 8'h00); chk(2, 8'h00); chk(3, 8'h00); chk(4, 8'h00);
    step();
    RST_N = 1;
    step();
    wr(4'd5, 8'h77);
    raddr_a = 4'd5;
    chk(0, 8'h77);
    step();
    RST_N = 0;
    #1;
    chk(0, 8'h00); chk(3, 8'h00);
    step();
    RST_N = 1;
    step();
    expect_zero_bank();
    sel_bank(1);
    expect_zero_bank();
    sel_bank(0);
    wr(4'd3, 8'h3C);
    acc_write_en = 1; reg_write_en = 1; waddr = 4'd3; data_in = 8'hA5;
    raddr_a = 4'd3; raddr_b = 4'd15;
    chk(2, 8'hA5); chk(0, 8'h3C); chk(1, 8'hA5);
    step();
    idle_inputs();
    chk(2, 8'hA5); chk(0, 8'h3C); chk(1, 8'hA5);
    step();
    reg_write_en = 1; waddr = 4'd2; data_in = 8'h11; bank_load = 1; bank_sel = 1; raddr_a = 4'd2;
    chk(0, 8'h11);
    step();
    bank_load = 0; data_in = 8'h22;
    chk(0, 8'h22);
    step();
    idle_inputs();
    chk(0, 8'h22); chk(2, 8'h00);
    step();
    bank_load = 1; bank_sel = 0;
    chk(0, 8'h22);
    step();
    bank_load = 0;
    chk(0, 8'h11); chk(2, 8'hA5);
    step();
    for (int i = 0; i < 16; i++) wr(4'(i), 8'(i));
    copy_req = 1; copy_dst = 1;
    chk(3, 8'h00);
    step();
    idle_inputs();
    sweep_wait(1'b1);
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL done_cnt after copy got=%0d want=1", done_cnt);
    end
    raddr_a = 4'd4;
    chk(0, 8'h04); chk(5, 8'd1);
    step();
    sel_bank(1);
    for (int i = 0; i < 16; i++) begin
      raddr_a = 4'(i);
      chk(0, 8'(i));
      step();
    end
    wr(4'd0, 8'hEE);
    clr_req = 1; copy_req = 1; copy_dst = 0;
    step();
    idle_inputs();
    sweep_wait(1'b0);
    if (done_cnt !== 2) begin
      bad++;
      $display("FAIL done_cnt after clear got=%0d want=2", done_cnt);
    end
    chk(5, 8'd2);
    expect_zero_bank();
    chk(2, 8'h00);
    sel_bank(0);
    for (int i = 0; i < 16; i++) begin
      raddr_a = 4'(i);
      chk(0, 8'(i));
      step();
    end
    copy_req = 1; copy_dst = 1;
    step();
    idle_inputs();
    for (int k = 0; k < 4; k++) step();
    chk(3, 8'h01);
    step();
    RST_N = 0;
    #1;
    chk(3, 8'h00); chk(4, 8'h00); chk(0, 8'h00); chk(2, 8'h00);
    step(); step();
    RST_N = 1;
    for (int k = 0; k < 20; k++) begin
      chk(4, 8'h00); chk(3, 8'h00);
      step();
    end
    if (done_cnt !== 2) begin
      bad++;
      $display("FAIL done_cnt after abort got=%0d want=2", done_cnt);
    end
    chk(5, 8'd2);
    expect_zero_bank();
    sel_bank(1);
    expect_zero_bank();
    step();
    if (bad !== 0 || total < 100) $display("FAIL summary total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
